// File: rtl/router_sync_ctrl.sv
// router_sync_ctrl
//
// Address-latch, write-steering and idle-timeout controller that sits
// between the router FSM and the three output FIFOs of a 1x3 router.
//
// - Latches the 2-bit destination address while the FSM is in address decode.
// - Steers the FSM's single write enable to the addressed FIFO.
// - Returns the addressed FIFO's full flag to the FSM.
// - Reports per-port valid as the inverse of each FIFO's empty flag.
// - Runs one idle timer per port. A port that holds data and is not read for
//   TIMEOUT consecutive cycles receives a one-cycle soft_reset pulse.
//
// Parameters
//   TIMEOUT : idle cycles (valid data, no read) before a soft reset; 2..2**CNT_W
//   CNT_W   : width of each per-port timeout counter
//
// Ports
//   clock                    : single clock, rising edge
//   reset                    : asynchronous, active-high; clears all state
//   detect_add               : FSM is in address decode; enables address capture
//   data_in[1:0]             : address field of the header byte
//   write_enb_reg            : FSM write request for the current packet
//   read_enb_0..2            : destination read strobes
//   empty_0..2, full_0..2    : FIFO status flags
//   write_enb[2:0]           : one-hot FIFO write enables (combinational)
//   fifo_full                : full flag of the addressed FIFO (combinational)
//   vld_out_0..2             : port has data (combinational)
//   soft_reset_0..2          : registered one-cycle timeout pulses
//
// Optional feature, macro ROUTER_SYNC_STICKY_EN:
//   clr_timeout              : clears the sticky timeout flags
//   timeout_flag[2:0]        : bit n sets when soft_reset_n is raised and holds
//                              until cleared; a set wins over a same-edge clear

module router_sync_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
`ifdef ROUTER_SYNC_STICKY_EN
  input  logic       clr_timeout,
  output logic [2:0] timeout_flag,
`endif
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       addr_p1;
  logic [CNT_W-1:0] cnt_p1  [3];
  logic [CNT_W-1:0] cnt_nxt [3];
  logic [2:0]       sr_p1;
  logic [2:0]       sr_nxt;
  logic [2:0]       vld;
  logic [2:0]       rd;

  // One timer step: returns {pulse, next_count}. The counter restarts on any
  // read or when the port has nothing to read, and folds back to zero on the
  // cycle it fires, so it never exceeds TIMEOUT-1.
  function automatic logic [CNT_W:0] timer_step(input logic             v,
                                                input logic             r,
                                                input logic [CNT_W-1:0] cnt);
    if (!v || r) begin
      return '0;
    end else if (cnt == CNT_LAST) begin
      return {1'b1, {CNT_W{1'b0}}};
    end else begin
      return {1'b0, cnt + CNT_W'(1)};
    end
  endfunction

  assign vld = ~{empty_2, empty_1, empty_0};
  assign rd  = {read_enb_2, read_enb_1, read_enb_0};

  assign vld_out_0 = vld[0];
  assign vld_out_1 = vld[1];
  assign vld_out_2 = vld[2];

  // Stage p0 -> p1: address capture; the last cycle with detect_add high wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_p1 <= 2'b00;
    end else if (detect_add) begin
      addr_p1 <= data_in;
    end
  end

  // Address 3 is not a port: no write enable and no full flag.
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (addr_p1)
      2'd0: begin
        write_enb = {2'b00, write_enb_reg};
        fifo_full = full_0;
      end
      2'd1: begin
        write_enb = {1'b0, write_enb_reg, 1'b0};
        fifo_full = full_1;
      end
      2'd2: begin
        write_enb = {write_enb_reg, 2'b00};
        fifo_full = full_2;
      end
      default: begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

  always_comb begin
    sr_nxt = 3'b000;
    for (int p = 0; p < 3; p++) begin
      cnt_nxt[p] = '0;
      {sr_nxt[p], cnt_nxt[p]} = timer_step(vld[p], rd[p], cnt_p1[p]);
    end
  end

  // Stage p0 -> p1: per-port idle timers and registered timeout pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 3; p++) begin
        cnt_p1[p] <= '0;
      end
      sr_p1 <= 3'b000;
    end else begin
      for (int p = 0; p < 3; p++) begin
        cnt_p1[p] <= cnt_nxt[p];
      end
      sr_p1 <= sr_nxt;
    end
  end

  assign soft_reset_0 = sr_p1[0];
  assign soft_reset_1 = sr_p1[1];
  assign soft_reset_2 = sr_p1[2];

`ifdef ROUTER_SYNC_STICKY_EN
  logic [2:0] flag_p1;

  // Stage p0 -> p1: sticky flags; a new pulse overrides a same-edge clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_p1 <= 3'b000;
    end else begin
      flag_p1 <= sr_nxt | (flag_p1 & {3{~clr_timeout}});
    end
  end

  assign timeout_flag = flag_p1;
`endif

endmodule
